// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM states, generator defaults and the tap predictor.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  localparam int unsigned LFSR_SIZE_DFLT = 7;
  localparam logic [7:0]  LFSR_POLY_DFLT = 8'b1100_0001;
  localparam logic [6:0]  LFSR_INIT_DFLT = 7'b111_1010;

  // Predictor operands are zero-extended to this width, so LFSR_SIZE must not exceed it.
  localparam int unsigned PRED_MAX_W = 32;

  function automatic logic lfsr_predict(input logic [PRED_MAX_W-1:0] state,
                                        input logic [PRED_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream input and status/counter outputs of the LFSR checker.
interface lfsr_checker_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 bit_valid;
  logic                 bit_in;
  logic                 cnt_clear;
  logic                 locked;
  logic                 err_pulse;
  logic [CNT_WIDTH-1:0] err_count;
  logic [CNT_WIDTH-1:0] bit_count;

  modport master (
    output bit_valid, bit_in, cnt_clear,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  bit_valid, bit_in, cnt_clear,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_shadow.sv
// Shadow Fibonacci LFSR: shifts in either the received bit or its own prediction.
module lfsr_shadow
  import lfsr_pkg::*;
#(
  parameter int unsigned N    = LFSR_SIZE_DFLT,
  parameter logic [N:0]  POLY = LFSR_POLY_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic step_i,
  input  logic use_pred_i,
  input  logic bit_i,
  output logic pred_c_o,
  output logic zero_c_o
);

  logic [N-1:0] shadow_q, shadow_d;

  assign pred_c_o = lfsr_predict(PRED_MAX_W'(shadow_q), PRED_MAX_W'(POLY[N:1]));
  assign zero_c_o = (shadow_q == '0);

  always_comb begin
    shadow_d = shadow_q;
    if (step_i) begin
      shadow_d = {shadow_q[N-2:0], use_pred_i ? pred_c_o : bit_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR stream checker: seeds a shadow LFSR, verifies it, then
// flywheels and counts mismatches while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned        LFSR_SIZE  = LFSR_SIZE_DFLT,
  parameter logic [LFSR_SIZE:0] LFSR_POLY  = LFSR_POLY_DFLT,
  parameter int unsigned        LOCK_COUNT = 16,
  parameter int unsigned        ERR_THRESH = 4,
  parameter int unsigned        CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);

  localparam int unsigned SEED_W = $clog2(LFSR_SIZE + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(ERR_THRESH + 1);

  lfsr_state_e          state_q, state_d;
  logic [SEED_W-1:0]    seed_q, seed_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

  logic pred_c;
  logic zero_c;
  logic use_pred_c;
  logic mismatch_c;

  lfsr_shadow #(
    .N    (LFSR_SIZE),
    .POLY (LFSR_POLY)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .step_i     (bus.bit_valid),
    .use_pred_i (use_pred_c),
    .bit_i      (bus.bit_in),
    .pred_c_o   (pred_c),
    .zero_c_o   (zero_c)
  );

  assign mismatch_c = bus.bit_in ^ pred_c;

  // Next-state, counter and shift-source selection.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    use_pred_c  = 1'b0;

    if (bus.bit_valid) begin
      case (state_q)
        SEED: begin
          if (seed_q == SEED_W'(LFSR_SIZE - 1)) begin
            state_d = VERIFY;
            seed_d  = '0;
            run_d   = '0;
          end else begin
            seed_d = seed_q + SEED_W'(1);
          end
        end
        VERIFY: begin
          if (zero_c) begin
            // The generator never holds all-zero, so this seed is bogus.
            state_d = SEED;
            seed_d  = '0;
            run_d   = '0;
          end else if (mismatch_c) begin
            state_d = SEED;
            seed_d  = SEED_W'(1);
            run_d   = '0;
          end else if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
            state_d = LOCKED;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        LOCKED: begin
          if (~&bit_cnt_q) bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
          if (mismatch_c) begin
            err_pulse_d = 1'b1;
            if (~&err_cnt_q) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            run_d = '0;
            if (miss_q == MISS_W'(ERR_THRESH - 1)) begin
              state_d = SEED;
              seed_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d     = miss_q + MISS_W'(1);
              use_pred_c = 1'b1;
            end
          end else begin
            use_pred_c = 1'b1;
            if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
              run_d  = '0;
              miss_d = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d = SEED;
          seed_d  = '0;
          run_d   = '0;
          miss_d  = '0;
        end
      endcase
    end

    if (bus.cnt_clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      seed_q      <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_cnt_q;
  assign bus.bit_count = bit_cnt_q;

endmodule
